// File: rtl/fc_pkg.sv
// Shared constants and helpers for the fully-connected layer blocks
// and their readout logic (word width, per-layer word counts, index width).
package fc_pkg;

    localparam int FC_DATA_WIDTH = 32;

    // Words per vector at each layer boundary.
    localparam int L14_IN  = 32;
    localparam int L14_OUT = 16;

    // Width of a word index for an n-word vector; at least one bit.
    function automatic int fc_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fc_vec_serializer_if.sv
// Bus bundle of fc_vec_serializer: wide vector capture side plus the
// word-stream side.
//   valid_in, i_data        : layer strobe and packed vector
//   in_ready                : status, a vector this cycle will be stored
//   o_data/o_index/o_last   : current word, its index, last-word flag
//   o_valid, o_ready        : stream handshake
//   overflow                : sticky, a vector was dropped
// slave is the serializer side, master the producer/consumer side.
interface fc_vec_serializer_if
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = FC_DATA_WIDTH,
    parameter int NUM_WORDS  = L14_OUT,
    parameter int IDX_W      = fc_idx_w(NUM_WORDS)
) ();

    logic                            valid_in;
    logic [DATA_WIDTH*NUM_WORDS-1:0] i_data;
    logic                            in_ready;
    logic [DATA_WIDTH-1:0]           o_data;
    logic                            o_valid;
    logic                            o_ready;
    logic [IDX_W-1:0]                o_index;
    logic                            o_last;
    logic                            overflow;

    modport slave (
        input  valid_in, i_data, o_ready,
        output in_ready, o_data, o_valid, o_index, o_last, overflow
    );

    modport master (
        output valid_in, i_data, o_ready,
        input  in_ready, o_data, o_valid, o_index, o_last, overflow
    );

endinterface

// File: rtl/fc_word_mux.sv
// Combinational NUM_WORDS-to-1 word select from a packed vector.
// Ports: vec (packed words, word k at k*DATA_WIDTH), sel (index), word (out).
module fc_word_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 16,
    parameter int IDX_W      = 4
) (
    input  logic [DATA_WIDTH*NUM_WORDS-1:0] vec,
    input  logic [IDX_W-1:0]                sel,
    output logic [DATA_WIDTH-1:0]           word
);

    always_comb begin
        word = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (sel == IDX_W'(k)) begin
                word = vec[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/fc_vec_serializer.sv
// Captures a packed FC-layer result vector on a one-cycle strobe and streams
// it out word by word over valid/ready, with a current + pending slot.
// Ports: clk, rst (async, active-high), bus (fc_vec_serializer_if.slave).
module fc_vec_serializer
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = FC_DATA_WIDTH,
    parameter int NUM_WORDS  = L14_OUT,
    parameter int IDX_W      = fc_idx_w(NUM_WORDS)
) (
    input logic                 clk,
    input logic                 rst,
    fc_vec_serializer_if.slave  bus
);

    localparam int VW = DATA_WIDTH * NUM_WORDS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [VW-1:0]    cur_buf, cur_buf_n;
    logic [VW-1:0]    pend_buf, pend_buf_n;
    logic             cur_full, cur_full_n;
    logic             pend_full, pend_full_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             ovf, ovf_n;

    logic                  last;
    logic                  xfer;
    logic                  done;
    logic [DATA_WIDTH-1:0] word;

    assign last = cur_full && (idx == LAST_IDX);
    assign xfer = cur_full && bus.o_ready;
    assign done = xfer && last;

    fc_word_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WORDS  (NUM_WORDS),
        .IDX_W      (IDX_W)
    ) u_mux (
        .vec  (cur_buf),
        .sel  (idx),
        .word (word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_buf   <= '0;
            pend_buf  <= '0;
            cur_full  <= 1'b0;
            pend_full <= 1'b0;
            idx       <= '0;
            ovf       <= 1'b0;
        end else begin
            cur_buf   <= cur_buf_n;
            pend_buf  <= pend_buf_n;
            cur_full  <= cur_full_n;
            pend_full <= pend_full_n;
            idx       <= idx_n;
            ovf       <= ovf_n;
        end
    end

    // Retire first (advance / finish the current vector), then place any
    // incoming vector into whichever slot that frees up.
    always_comb begin
        cur_buf_n   = cur_buf;
        pend_buf_n  = pend_buf;
        cur_full_n  = cur_full;
        pend_full_n = pend_full;
        idx_n       = idx;
        ovf_n       = ovf;

        if (xfer) begin
            idx_n = last ? '0 : idx + IDX_W'(1);
        end

        if (done) begin
            if (pend_full) begin
                cur_buf_n   = pend_buf;
                pend_full_n = 1'b0;
            end else begin
                cur_full_n = 1'b0;
            end
        end

        if (bus.valid_in) begin
            if (!cur_full) begin
                cur_buf_n  = bus.i_data;
                cur_full_n = 1'b1;
                idx_n      = '0;
            end else if (!pend_full) begin
                if (done) begin
                    cur_buf_n  = bus.i_data;
                    cur_full_n = 1'b1;
                end else begin
                    pend_buf_n  = bus.i_data;
                    pend_full_n = 1'b1;
                end
            end else if (done) begin
                // cur_buf_n already took the old pending vector above.
                pend_buf_n  = bus.i_data;
                pend_full_n = 1'b1;
            end else begin
                ovf_n = 1'b1;
            end
        end
    end

    always_comb begin
        bus.o_valid  = cur_full;
        bus.o_index  = idx;
        bus.o_last   = last;
        bus.o_data   = cur_full ? word : '0;
        bus.in_ready = !pend_full;
        bus.overflow = ovf;
    end

endmodule

// File: tb/tb_fc_vec_serializer.sv
// Self-checking bench for fc_vec_serializer: directed scenarios plus random
// traffic against a word-queue reference model.
module tb_fc_vec_serializer;

    localparam int DW = 32;
    localparam int NW = 16;
    localparam int VW = DW * NW;

    typedef struct {
        logic [DW-1:0] w;
        int            k;
    } ent_t;

    logic clk;
    logic rst;

    fc_vec_serializer_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) bus ();

    fc_vec_serializer #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t exp_q[$];
    logic m_ovf;
    int   n_vec;
    int   n_err;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        int held;
        held = (exp_q.size() + NW - 1) / NW;
        if (exp_q.size() > 0) begin
            chk("o_valid", 64'(bus.o_valid), 64'(1));
            chk("o_data", 64'(bus.o_data), 64'(exp_q[0].w));
            chk("o_index", 64'(bus.o_index), 64'(exp_q[0].k));
            chk("o_last", 64'(bus.o_last), 64'(exp_q[0].k == NW - 1));
        end else begin
            chk("o_valid_idle", 64'(bus.o_valid), 64'(0));
            chk("o_data_idle", 64'(bus.o_data), 64'(0));
            chk("o_index_idle", 64'(bus.o_index), 64'(0));
            chk("o_last_idle", 64'(bus.o_last), 64'(0));
        end
        chk("in_ready", 64'(bus.in_ready), 64'(held < 2));
        chk("overflow", 64'(bus.overflow), 64'(m_ovf));
        chk("pend_implies_cur",
            64'(!u_dut.pend_full || u_dut.cur_full), 64'(1));
    endtask

    task automatic push_vec(input logic [VW-1:0] v);
        ent_t e;
        for (int k = 0; k < NW; k++) begin
            e.w = v[k*DW +: DW];
            e.k = k;
            exp_q.push_back(e);
        end
    endtask

    // Model one clock edge with the inputs currently driven, then check.
    task automatic tick();
        int held;
        if (exp_q.size() > 0 && bus.o_ready) void'(exp_q.pop_front());
        if (bus.valid_in) begin
            held = (exp_q.size() + NW - 1) / NW;
            if (held < 2) push_vec(bus.i_data);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [VW-1:0] v);
        bus.valid_in = 1'b1;
        bus.i_data   = v;
        tick();
        bus.valid_in = 1'b0;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < NW; k++) v[k*DW +: DW] = $urandom;
        return v;
    endfunction

    // Asynchronous assert mid-cycle, released just after an edge.
    task automatic do_reset();
        bus.valid_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        m_ovf = 1'b0;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        logic [VW-1:0] v;
        n_vec = 0;
        n_err = 0;
        m_ovf = 1'b0;
        rst = 1'b0;
        bus.valid_in = 1'b0;
        bus.i_data   = '0;
        bus.o_ready  = 1'b0;

        do_reset();

        // Single vector with known words, sink always ready.
        for (int k = 0; k < NW; k++) v[k*DW +: DW] = 32'h3F80_0000 + k;
        bus.o_ready = 1'b1;
        send(v);
        ticks(NW + 3);

        // Back-pressure pattern 1,0,0,1 repeating.
        send(v);
        for (int i = 0; i < 4 * NW + 4; i++) begin
            bus.o_ready = (i % 4 == 0) || (i % 4 == 3);
            tick();
        end

        // Back-to-back A and B.
        bus.o_ready = 1'b1;
        send(rand_vec());
        send(rand_vec());
        ticks(2 * NW + 3);

        // A, B, C with sink stalled: C dropped.
        bus.o_ready = 1'b0;
        send(rand_vec());
        send(rand_vec());
        send(rand_vec());
        ticks(3);
        bus.o_ready = 1'b1;
        ticks(2 * NW + 3);
        do_reset();

        // C lands on A's done edge with B pending.
        bus.o_ready = 1'b1;
        send(rand_vec());
        send(rand_vec());
        ticks(NW - 2);
        send(rand_vec());
        ticks(3 * NW);

        // C lands on A's done edge with nothing pending.
        send(rand_vec());
        ticks(NW - 1);
        send(rand_vec());
        ticks(2 * NW + 2);

        // Reset mid-stream at index 7, pending full, overflow set.
        send(rand_vec());
        send(rand_vec());
        send(rand_vec());
        ticks(5);
        chk("idx7_before_rst", 64'(bus.o_index), 64'(7));
        do_reset();
        bus.o_ready = 1'b1;
        send(rand_vec());
        ticks(NW + 2);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bus.o_ready  = ($urandom_range(0, 3) != 0);
            bus.valid_in = ($urandom_range(0, 9) == 0);
            bus.i_data   = rand_vec();
            tick();
        end
        bus.valid_in = 1'b0;
        bus.o_ready  = 1'b1;
        ticks(3 * NW);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
